instr_fetch_unit: RTL and testbench

- Fetch stage of the 24-bit CPU, directly upstream of the control unit.
- Holds the PC and requests instructions from instruction memory with a req/ready handshake.
- Latches each 24-bit instruction and presents its 4-bit opcode to the control unit.
- Selects the next PC from the control unit's Jump/Branch outputs and the ALU Zero flag once execute signals completion.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/next_pc_sel.sv | 36 +++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit CPU: opcodes, instruction field positions
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned JTGT_W  = 20;

  localparam logic [OPC_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_LW    = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SW    = 4'b0011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_RTYPE = 4'b0110;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'b1111;

  localparam int unsigned OPC_MSB  = 23;
  localparam int unsigned OPC_LSB  = 20;
  localparam int unsigned RS_MSB   = 19;
  localparam int unsigned RS_LSB   = 16;
  localparam int unsigned RT_MSB   = 15;
  localparam int unsigned RT_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned JTGT_MSB = 19;
  localparam int unsigned JTGT_LSB = 0;

  typedef enum logic [1:0] {
    StFetch,
    StIssue,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jump target, taken BEQ (PC+1+sext(imm8))
// or sequential PC+1, all wrapping modulo 2^PC_W.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0]   i_pc,
  input  logic [JTGT_W-1:0] i_jtgt,
  input  logic              i_jump,
  input  logic              i_branch,
  input  logic              i_zero,
  output logic [PC_W-1:0]   o_next_pc
);

  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_br_pc;
  logic [PC_W-1:0] w_jmp_pc;
  logic [PC_W-1:0] w_imm_ext;

  // imm8 lives in the low byte of the jump-target field
  assign w_imm_ext = PC_W'($signed(i_jtgt[IMM_MSB:IMM_LSB]));
  assign w_jmp_pc  = PC_W'(i_jtgt);
  assign w_seq_pc  = i_pc + PC_W'(1);
  assign w_br_pc   = w_seq_pc + w_imm_ext;

  always_comb begin
    o_next_pc = w_seq_pc;
    if (i_jump) begin
      o_next_pc = w_jmp_pc;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_br_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction per FETCH/ISSUE round trip
// and holds it for the control unit until execute reports completion.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [OPC_W-1:0] HALT_OP  = OP_HALT
) (
  input  logic               Clock,
  input  logic               ResetN,
  output logic [PC_W-1:0]    ImemAddr,
  output logic               ImemReq,
  input  logic               ImemReady,
  input  logic [INSTR_W-1:0] ImemData,
  input  logic               Jump,
  input  logic               Branch,
  input  logic               Zero,
  input  logic               ExecDone,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [OPC_W-1:0]   Opcode,
  output logic [PC_W-1:0]    PcOut,
  output logic               Halted
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic               r_req;
  logic               w_req_nxt;
  logic               w_latch;
  logic               w_pc_load;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_out;
  logic [PC_W-1:0]    w_next_pc;
  logic [INSTR_W-1:0] r_instr;

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_next_pc_sel (
    .i_pc      (r_pc),
    .i_jtgt    (r_instr[JTGT_MSB:JTGT_LSB]),
    .i_jump    (Jump),
    .i_branch  (Branch),
    .i_zero    (Zero),
    .o_next_pc (w_next_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_latch     = 1'b0;
    w_pc_load   = 1'b0;
    InstrValid  = 1'b0;
    Halted      = 1'b0;
    case (r_state)
      StFetch: begin
        // Ready only counts against a live request; stale responses are dropped
        if (!r_req) begin
          w_req_nxt = 1'b1;
        end else if (ImemReady) begin
          w_latch     = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = (ImemData[OPC_MSB:OPC_LSB] == HALT_OP) ? StHalt : StIssue;
        end
      end
      StIssue: begin
        InstrValid = 1'b1;
        if (ExecDone) begin
          w_pc_load   = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = StFetch;
        end
      end
      StHalt: begin
        InstrValid = 1'b1;
        Halted     = 1'b1;
        w_req_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = StFetch;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state  <= StFetch;
      r_req    <= 1'b0;
      r_pc     <= RESET_PC;
      r_pc_out <= RESET_PC;
      r_instr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      if (w_latch) begin
        r_instr  <= ImemData;
        r_pc_out <= r_pc;
      end
      if (w_pc_load) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign ImemAddr = r_pc;
  assign ImemReq  = r_req;
  assign Instr    = r_instr;
  assign Opcode   = r_instr[OPC_MSB:OPC_LSB];
  assign PcOut    = r_pc_out;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory/control-unit responders, a phase-level
// reference model checked every cycle, and directed fetch-trace scenarios.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int PC_W  = 16;
  localparam int PCMOD = 1 << PC_W;
  localparam logic [3:0] OP_JMP_TB = 4'h5;  // bench control unit: Jump only
  localparam logic [3:0] OP_JB_TB  = 4'h7;  // bench control unit: Jump and Branch

  logic            Clock;
  logic            ResetN;
  logic [PC_W-1:0] ImemAddr;
  logic            ImemReq;
  logic            ImemReady;
  logic [23:0]     ImemData;
  logic            Jump, Branch, Zero, ExecDone;
  logic            InstrValid;
  logic [23:0]     Instr;
  logic [3:0]      Opcode;
  logic [PC_W-1:0] PcOut;
  logic            Halted;

  instr_fetch_unit #(
    .PC_W (PC_W)
  ) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .ImemAddr   (ImemAddr),
    .ImemReq    (ImemReq),
    .ImemReady  (ImemReady),
    .ImemData   (ImemData),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero),
    .ExecDone   (ExecDone),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .Opcode     (Opcode),
    .PcOut      (PcOut),
    .Halted     (Halted)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus responders ----------------
  bit [23:0] mem [int];
  int  dut_trace[$];
  bit  force_ready, exec_noise, zero_val, tgl;
  int  ready_delay, exec_delay, rd_cnt, ex_cnt;

  function automatic logic [23:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 24'h000000;
  endfunction

  initial begin
    rd_cnt = 0;
    ex_cnt = 0;
    tgl    = 1'b0;
    forever begin
      @(negedge Clock);
      #1;
      if (ImemReq) begin
        ImemReady = (rd_cnt >= ready_delay);
        if (ImemReady) dut_trace.push_back(int'(ImemAddr));
        rd_cnt++;
      end else begin
        ImemReady = force_ready;
        rd_cnt = 0;
      end
      ImemData = mem_rd(int'(ImemAddr));
      if (InstrValid && !Halted) begin
        if (ex_cnt >= exec_delay) begin
          ExecDone = 1'b1;
          Jump     = (Instr[23:20] == OP_JMP_TB) || (Instr[23:20] == OP_JB_TB);
          Branch   = (Instr[23:20] == OP_BEQ) || (Instr[23:20] == OP_JB_TB);
          Zero     = zero_val;
        end else begin
          {ExecDone, Jump, Branch, Zero} = 4'b0111;  // garbage before the done cycle
        end
        ex_cnt++;
      end else begin
        ex_cnt   = 0;
        ExecDone = exec_noise & tgl;
        Jump     = exec_noise;
        Branch   = exec_noise;
        Zero     = exec_noise;
        tgl      = ~tgl;
      end
    end
  end

  // ---------------- reference model ----------------
  // phase 0: fetching, 1: instruction held for execute, 2: halted
  int        m_phase, m_pc, m_pcout;
  bit        m_req;
  bit [23:0] m_instr;

  function automatic int exp_next(input int pc, input bit [23:0] ins,
                                  input bit j, input bit b, input bit z);
    int imm;
    if (j) return int'(ins[19:0]) % PCMOD;
    if (b && z) begin
      imm = int'(ins[7:0]);
      if (imm > 127) imm = imm - 256;
      return (pc + 1 + imm + PCMOD) % PCMOD;
    end
    return (pc + 1) % PCMOD;
  endfunction

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_phase <= 0;
      m_req   <= 1'b0;
      m_pc    <= 0;
      m_pcout <= 0;
      m_instr <= 24'h0;
    end else if (m_phase == 0) begin
      if (!m_req) begin
        m_req <= 1'b1;
      end else if (ImemReady) begin
        m_instr <= ImemData;
        m_pcout <= m_pc;
        m_req   <= 1'b0;
        m_phase <= (ImemData[23:20] == 4'hF) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (ExecDone) begin
        m_pc    <= exp_next(m_pc, m_instr, Jump, Branch, Zero);
        m_req   <= 1'b1;
        m_phase <= 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (ResetN) begin
      chk("req", int'(ImemReq), int'(m_req));
      if (m_req) chk("addr", int'(ImemAddr), m_pc);
      chk("valid", int'(InstrValid), int'(m_phase != 0));
      chk("halted", int'(Halted), int'(m_phase == 2));
      if (m_phase != 0) begin
        chk("instr", int'(Instr), int'(m_instr));
        chk("opcode", int'(Opcode), int'(m_instr[23:20]));
        chk("pcout", int'(PcOut), m_pcout);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic start_reset();
    @(negedge Clock);
    #2;
    ResetN = 1'b0;
    mem.delete();
    repeat (2) @(negedge Clock);
    dut_trace.delete();
  endtask

  task automatic release_reset();
    @(negedge Clock);
    #2;
    ResetN = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cyc);
    int c = 0;
    while (!Halted && c < max_cyc) begin
      @(negedge Clock);
      c++;
    end
    chk("halt_reached", int'(Halted), 1);
  endtask

  task automatic chk_trace(input string name, input int exp[$], input bit exact);
    if (exact) chk({name, "_len"}, dut_trace.size(), exp.size());
    else chk({name, "_len_min"}, int'(dut_trace.size() >= exp.size()), 1);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dut_trace.size()) chk($sformatf("%s[%0d]", name, i), dut_trace[i], exp[i]);
    end
  endtask

  task automatic load_beq_mem();
    mem[0]  = 24'h50000A;
    mem[10] = 24'h4120FC;
    mem[7]  = 24'hF00000;
    mem[11] = 24'hF00000;
  endtask

  initial begin
    int exp_q[$];
    int c;
    ResetN = 1'b0; ImemReady = 1'b0; ImemData = '0;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; ExecDone = 1'b0;
    force_ready = 1'b0; exec_noise = 1'b0; zero_val = 1'b0;
    ready_delay = 0; exec_delay = 0;
    repeat (2) @(negedge Clock);
    chk("rst_req", int'(ImemReq), 0);
    chk("rst_valid", int'(InstrValid), 0);
    chk("rst_halted", int'(Halted), 0);
    chk("rst_addr", int'(ImemAddr), 0);

    // Ready tied high, sequential flow into HALT, then ExecDone noise while halted
    mem[0] = 24'h123456; mem[1] = 24'h1000AA; mem[2] = 24'h212345;
    mem[3] = 24'h600000; mem[4] = 24'hF00000;
    force_ready = 1'b1; exec_delay = 1;
    release_reset();
    @(negedge Clock);
    chk("c1_req", int'(ImemReq), 1);
    chk("c1_addr", int'(ImemAddr), 0);
    chk("c1_valid", int'(InstrValid), 0);
    @(negedge Clock);
    chk("c2_valid", int'(InstrValid), 1);
    chk("c2_opcode", int'(Opcode), 1);
    chk("c2_instr", int'(Instr), 24'h123456);
    run_until_halt(100);
    exp_q = {0, 1, 2, 3, 4};
    chk_trace("seq", exp_q, 1'b1);
    chk("halt_instr", int'(Instr), 24'hF00000);
    chk("halt_pcout", int'(PcOut), 4);
    exec_noise = 1'b1;
    repeat (20) begin
      @(negedge Clock);
      chk("halt_req_low", int'(ImemReq), 0);
      chk("halt_flag", int'(Halted), 1);
    end
    exec_noise = 1'b0; exec_delay = 0; force_ready = 1'b0;

    // Jump target truncated to 0xFFFF, then sequential wrap to 0
    start_reset();
    mem[0] = 24'h5AFFFF; mem[65535] = 24'h100000;
    release_reset();
    repeat (12) @(negedge Clock);
    exp_q = {0, 65535, 0, 65535};
    chk_trace("wrap", exp_q, 1'b0);

    // BEQ at 10 with imm -4: taken -> 7, not taken -> 11
    start_reset();
    load_beq_mem(); zero_val = 1'b1;
    release_reset();
    run_until_halt(100);
    exp_q = {0, 10, 7};
    chk_trace("beq_taken", exp_q, 1'b1);
    chk("beq_taken_pcout", int'(PcOut), 7);
    start_reset();
    load_beq_mem(); zero_val = 1'b0;
    release_reset();
    run_until_halt(100);
    exp_q = {0, 10, 11};
    chk_trace("beq_not_taken", exp_q, 1'b1);

    // Taken branch at 0 with imm -4 wraps below zero
    start_reset();
    mem[0] = 24'h4000FC; mem[65533] = 24'hF00000; zero_val = 1'b1;
    release_reset();
    run_until_halt(100);
    exp_q = {0, 65533};
    chk_trace("beq_wrap", exp_q, 1'b1);

    // Jump overrides a taken branch
    start_reset();
    mem[0] = 24'h700040; mem[64] = 24'hF00000; mem[65] = 24'hF00000; zero_val = 1'b1;
    release_reset();
    run_until_halt(100);
    exp_q = {0, 64};
    chk_trace("jump_over_branch", exp_q, 1'b1);
    zero_val = 1'b0;

    // Three wait states: request and address hold, single latch on the ready cycle
    start_reset();
    mem[0] = 24'h123456; mem[1] = 24'hF00000; ready_delay = 3;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk($sformatf("ws_req%0d", i), int'(ImemReq), 1);
      chk($sformatf("ws_addr%0d", i), int'(ImemAddr), 0);
      chk($sformatf("ws_valid%0d", i), int'(InstrValid), 0);
    end
    @(negedge Clock);
    chk("ws_latched", int'(InstrValid), 1);
    chk("ws_single", dut_trace.size(), 1);
    run_until_halt(100);
    exp_q = {0, 1};
    chk_trace("ws", exp_q, 1'b1);

    // Reset mid-wait: request drops asynchronously, stale ready is dropped
    start_reset();
    mem[0] = 24'h500020; mem[32] = 24'h100000; ready_delay = 2;
    release_reset();
    c = 0;
    while (!(ImemReq && ImemAddr == 16'h0020) && c < 50) begin
      @(negedge Clock);
      c++;
    end
    chk("mid_reach", int'(ImemReq && ImemAddr == 16'h0020), 1);
    #2;
    ResetN = 1'b0;
    #1;
    chk("mid_req_async", int'(ImemReq), 0);
    chk("mid_addr_async", int'(ImemAddr), 0);
    chk("mid_valid_async", int'(InstrValid), 0);
    force_ready = 1'b1; ready_delay = 0;
    repeat (2) @(negedge Clock);
    dut_trace.delete();
    release_reset();
    @(negedge Clock);
    chk("post_req", int'(ImemReq), 1);
    chk("post_addr", int'(ImemAddr), 0);
    chk("post_valid", int'(InstrValid), 0);
    repeat (10) @(negedge Clock);
    exp_q = {0, 32};
    chk_trace("post", exp_q, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

endmodule
